// File: rtl/spi_result_tx.sv
// SPI slave MISO side for the accelerator result path: holds the latest result and
// serialises a 3-byte {status, result, check} frame while the host clocks cs_n/sclk.
module spi_result_tx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic [7:0] result,
  input  logic       result_valid,
  output logic       miso,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAD   = 2'd2;

  // Bit 0 is the newest sample; edges are judged on the two oldest bits.
  logic [SYNC_STAGES:0] sclk_sync;
  logic [SYNC_STAGES:0] cs_sync;

  logic [1:0]  state;
  logic [23:0] sr;
  logic [4:0]  bitcnt;
  logic [7:0]  hold;
  logic        fresh;
  logic        new_res;
  logic [3:0]  seq;

  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [7:0] b0, b1, b2;

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES];
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES];
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_sync[SYNC_STAGES];

  assign b0 = {fresh, 3'b000, seq};
  assign b1 = hold;
  assign b2 = b0 ^ b1;

  assign miso = (state == SHIFT) & sr[23];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-1:0], cs_n};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      bitcnt     <= '0;
      hold       <= '0;
      fresh      <= 1'b0;
      new_res    <= 1'b0;
      seq        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (result_valid) begin
        hold    <= result;
        fresh   <= 1'b1;
        new_res <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            sr      <= {b0, b1, b2};
            bitcnt  <= '0;
            new_res <= result_valid;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            if (bitcnt != 5'd31)
              bitcnt <= bitcnt + 5'd1;
            // Only the snapshotted result is consumed; a capture during the frame stays fresh.
            if (bitcnt == 5'd15 && !new_res && !result_valid)
              fresh <= 1'b0;
            if (bitcnt == 5'd23) begin
              frame_done <= 1'b1;
              seq        <= seq + 4'd1;
              state      <= PAD;
            end
          end else if (sclk_fall) begin
            sr <= {sr[22:0], 1'b0};
          end
        end
        PAD: begin
          if (cs_rise)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
